// File: rtl/chip8_mem_pkg.sv
// Shared CHIP-8 memory constants, requester indices and memory-operation type
// used by the arbiter, its interface and any other shared-memory clients.
package chip8_mem_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int MEMORY_SIZE = 4096;

    localparam int REQ_CPU  = 0;
    localparam int REQ_GFX  = 1;
    localparam int REQ_LOAD = 2;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } mem_op_e;

    // Index width for an n-entry select; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the CHIP-8 memory arbiter: flattened per-requester
// request fields plus broadcast read response. req_lock exists only with MEM_ARB_LOCK_EN.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = chip8_mem_pkg::ADDR_W,
    parameter int DATA_W  = chip8_mem_pkg::DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif

`ifdef MEM_ARB_LOCK_EN
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_lock,
        output req_ready, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_lock,
        input  req_ready, resp_valid, resp_data
    );
`else
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data
    );
`endif

endinterface

// File: rtl/mem_rr_pick.sv
// Combinational rotating-priority picker: the first set bit of valid at or
// after ptr (wrapping modulo N) wins; an out-of-range ptr behaves as 0.
module mem_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] base_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Compare in IDX_W+1 bits so a power-of-two N does not alias to zero.
    assign base_s = ({1'b0, ptr} >= N_EXT) ? '0 : ptr;

    // Walk the candidates from base_s upward with wrap; latch the first hit.
    always_comb begin
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        hit_s  = 1'b0;
        cand_s = base_s;
        for (int k = 0; k < N; k++) begin
            hit_s         = ~found & valid[cand_s];
            grant[cand_s] = grant[cand_s] | hit_s;
            idx           = hit_s ? cand_s : idx;
            found         = found | hit_s;
            cand_s        = (cand_s == LAST) ? '0 : cand_s + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single CHIP-8 memory between NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to add req_lock burst locking; default build is pure round-robin.
module mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = chip8_mem_pkg::ADDR_W,
    parameter int DATA_W  = chip8_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data
);

    localparam int               PTR_W    = chip8_mem_pkg::idx_width(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]       rr_ptr_r;
    logic                   resp_pending_r;
    logic [PTR_W-1:0]       resp_owner_r;

    logic [NUM_REQ-1:0]     eligible_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [PTR_W-1:0]       next_ptr_s;
    logic                   found_s;
    logic                   transfer_s;
    logic                   sel_write_s;
    logic [ADDR_W-1:0]      sel_addr_s;
    logic [DATA_W-1:0]      sel_wdata_s;
    chip8_mem_pkg::mem_op_e op_s;

`ifdef MEM_ARB_LOCK_EN
    logic                   lock_active_r;
    logic [PTR_W-1:0]       lock_owner_r;
    logic [NUM_REQ-1:0]     owner_mask_s;
    logic                   lock_clear_s;

    // While a burst lock is held only its owner competes for the memory.
    always_comb begin
        owner_mask_s               = '0;
        owner_mask_s[lock_owner_r] = 1'b1;
        if (lock_active_r) begin
            eligible_s = bus.req_valid & owner_mask_s;
        end else begin
            eligible_s = bus.req_valid;
        end
    end

    // Owner releases by transferring without lock, or by going idle unlocked.
    assign lock_clear_s = ~bus.req_lock[lock_owner_r] &
                          (transfer_s | ~bus.req_valid[lock_owner_r]);

    // Lock state: set by a locked transfer, cleared on owner release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active_r <= 1'b0;
            lock_owner_r  <= '0;
        end else if (lock_active_r) begin
            lock_active_r <= ~lock_clear_s;
        end else if (transfer_s && bus.req_lock[grant_idx_s]) begin
            lock_active_r <= 1'b1;
            lock_owner_r  <= grant_idx_s;
        end
    end
`else
    assign eligible_s = bus.req_valid;
`endif

    mem_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .valid (eligible_s),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (grant_idx_s),
        .found (found_s)
    );

    // Gating with rst keeps a request arriving alongside reset from issuing.
    assign transfer_s = found_s & ~rst;
    assign next_ptr_s = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + PTR_W'(1);

    // Grant is presented to requesters only outside reset.
    always_comb begin
        if (rst) begin
            bus.req_ready = '0;
        end else begin
            bus.req_ready = grant_s;
        end
    end

    // One-hot AND-OR select of the granted requester's fields.
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_write_s = sel_write_s | (grant_s[i] & bus.req_write[i]);
            sel_addr_s  = sel_addr_s  | (bus.req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{grant_s[i]}});
            sel_wdata_s = sel_wdata_s | (bus.req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Classify this cycle's memory operation.
    always_comb begin
        if (!transfer_s) begin
            op_s = chip8_mem_pkg::OP_IDLE;
        end else if (sel_write_s) begin
            op_s = chip8_mem_pkg::OP_WRITE;
        end else begin
            op_s = chip8_mem_pkg::OP_READ;
        end
    end

    // Memory port drive; unused address/data lines sit at zero.
    always_comb begin
        mem_read       = 1'b0;
        mem_read_addr  = '0;
        mem_write      = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        case (op_s)
            chip8_mem_pkg::OP_READ: begin
                mem_read      = 1'b1;
                mem_read_addr = sel_addr_s;
            end
            chip8_mem_pkg::OP_WRITE: begin
                mem_write      = 1'b1;
                mem_write_addr = sel_addr_s;
                mem_write_data = sel_wdata_s;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // Pointer rotation and read-response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r       <= '0;
            resp_pending_r <= 1'b0;
            resp_owner_r   <= '0;
        end else begin
            if (transfer_s) begin
                rr_ptr_r <= next_ptr_s;
            end
            resp_pending_r <= (op_s == chip8_mem_pkg::OP_READ);
            if (op_s == chip8_mem_pkg::OP_READ) begin
                resp_owner_r <= grant_idx_s;
            end
        end
    end

    // Read data arrives one cycle after issue and is steered by the owner tag.
    always_comb begin
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.resp_valid[i] = resp_pending_r & (resp_owner_r == PTR_W'(i));
        end
        if (resp_pending_r) begin
            bus.resp_data = mem_read_data;
        end else begin
            bus.resp_data = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of per-cycle requests and
// expected grants, a response scoreboard, and hand sequences for reset and locking.
module tb_mem_arbiter;
    import chip8_mem_pkg::*;

    localparam int N  = 3;
    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;

    typedef struct {
        logic                  rst_before;
        logic [N-1:0]          valid;
        logic [N-1:0]          write;
        logic [N-1:0][AW-1:0]  addr;
        logic [N-1:0][DW-1:0]  wdata;
        logic [N-1:0]          lock;
        logic [N-1:0]          exp_ready;
    } vec_t;

    typedef struct {
        int          owner;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_init;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] mem_read_data, mem_write_data;
    logic [DW-1:0] mem    [MEMORY_SIZE];
    logic [DW-1:0] shadow [MEMORY_SIZE];

    resp_t sbq[$];
    vec_t  vecs[$];
    vec_t  v;
    int    checks = 0;
    int    errors = 0;
    int    gfx_wait = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .mem_read       (mem_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return 8'(a) ^ 8'h3C;
    endfunction

    // Synchronous memory: write commits on posedge, read data valid next cycle.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < MEMORY_SIZE; a++) mem[a] <= pat(a);
            mem_read_data <= 8'h00;
        end else begin
            if (mem_write) mem[mem_write_addr] <= mem_write_data;
            if (mem_read)  mem_read_data <= mem[mem_read_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] valid, input logic [N-1:0] write,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [N-1:0] exp_ready);
        vec_t r;
        r.rst_before = 1'b0;
        r.valid      = valid;
        r.write      = write;
        r.addr[0]    = a0;
        r.addr[1]    = a1;
        r.addr[2]    = a2;
        r.wdata[0]   = d0;
        r.wdata[1]   = d1;
        r.wdata[2]   = d2;
        r.lock       = 3'b000;
        r.exp_ready  = exp_ready;
        return r;
    endfunction

    task automatic drive(input vec_t d);
        bus.req_valid = d.valid;
        bus.req_write = d.write;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = d.addr[i];
            bus.req_wdata[i*DW +: DW] = d.wdata[i];
        end
`ifdef MEM_ARB_LOCK_EN
        bus.req_lock = d.lock;
`endif
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(1) << e.owner);
            check({tag, ".resp_data"},  32'(bus.resp_data),  32'(e.data));
        end else begin
            check({tag, ".resp_idle"}, 32'(bus.resp_valid), 32'd0);
        end
    endtask

    // One cycle: drive after posedge, compare at negedge, update scoreboard.
    task automatic apply(input vec_t d, input string tag);
        logic          exp_rd, exp_wr;
        logic [AW-1:0] exp_ra, exp_wa;
        logic [DW-1:0] exp_wd;
        @(posedge clk); #1;
        drive(d);
        @(negedge clk);
        exp_rd = 1'b0; exp_wr = 1'b0;
        exp_ra = 12'h000; exp_wa = 12'h000; exp_wd = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (d.exp_ready[i] && d.write[i]) begin
                exp_wr = 1'b1; exp_wa = d.addr[i]; exp_wd = d.wdata[i];
            end else if (d.exp_ready[i]) begin
                exp_rd = 1'b1; exp_ra = d.addr[i];
            end
        end
        check({tag, ".ready"},      32'(bus.req_ready),   32'(d.exp_ready));
        check({tag, ".mem_read"},   32'(mem_read),        32'(exp_rd));
        check({tag, ".read_addr"},  32'(mem_read_addr),   32'(exp_ra));
        check({tag, ".mem_write"},  32'(mem_write),       32'(exp_wr));
        check({tag, ".write_addr"}, 32'(mem_write_addr),  32'(exp_wa));
        check({tag, ".write_data"}, 32'(mem_write_data),  32'(exp_wd));
        check_resp(tag);
        for (int i = 0; i < N; i++) begin
            if (d.exp_ready[i] && d.write[i]) shadow[d.addr[i]] = d.wdata[i];
            else if (d.exp_ready[i]) sbq.push_back('{i, shadow[d.addr[i]]});
        end
        if (bus.req_valid[REQ_GFX] && bus.req_ready[REQ_GFX]) begin
            check({tag, ".gfx_starve"}, 32'(gfx_wait < N), 32'd1);
            gfx_wait = 0;
        end else if (bus.req_valid[REQ_GFX]) begin
            gfx_wait++;
        end else begin
            gfx_wait = 0;
        end
    endtask

    // Reset with live requests (including a write) that must all be suppressed.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(3'b111, 3'b001, 12'h3FE, 12'h051, 12'h052, 8'h5A, 8'h00, 8'h00, 3'b000));
        @(negedge clk);
        check("rst.ready",      32'(bus.req_ready),  32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.mem_read",   32'(mem_read),       32'd0);
        check("rst.mem_write",  32'(mem_write),      32'd0);
        sbq.delete();
        gfx_wait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < MEMORY_SIZE; a++) shadow[a] = pat(a);
        rst      = 1'b1;
        mem_init = 1'b1;
        drive(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;

        // Write-then-read of the same address.
        vecs.push_back(mk(3'b001, 3'b001, 12'h200, 12'h000, 12'h000, 8'hA5, 8'h00, 8'h00, 3'b001));
        vecs.push_back(mk(3'b001, 3'b000, 12'h200, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b001));
        vecs.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
        // All three reading from reset: grants 0,1,2 back to back.
        vecs.push_back(mk(3'b111, 3'b000, 12'h050, 12'h051, 12'h052, 8'h00, 8'h00, 8'h00, 3'b001));
        vecs.push_back(mk(3'b110, 3'b000, 12'h050, 12'h051, 12'h052, 8'h00, 8'h00, 8'h00, 3'b010));
        vecs.push_back(mk(3'b100, 3'b000, 12'h050, 12'h051, 12'h052, 8'h00, 8'h00, 8'h00, 3'b100));
        vecs.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
        // GFX continuously valid amid CPU writes and loader reads.
        vecs.push_back(mk(3'b111, 3'b001, 12'h300, 12'h123, 12'h300, 8'h11, 8'h00, 8'h00, 3'b001));
        vecs.push_back(mk(3'b111, 3'b001, 12'h301, 12'h123, 12'h300, 8'h22, 8'h00, 8'h00, 3'b010));
        vecs.push_back(mk(3'b111, 3'b001, 12'h301, 12'h124, 12'h300, 8'h22, 8'h00, 8'h00, 3'b100));
        vecs.push_back(mk(3'b111, 3'b001, 12'h301, 12'h124, 12'h301, 8'h22, 8'h00, 8'h00, 3'b001));
        vecs.push_back(mk(3'b110, 3'b000, 12'h000, 12'h124, 12'h301, 8'h00, 8'h00, 8'h00, 3'b010));
        vecs.push_back(mk(3'b100, 3'b000, 12'h000, 12'h000, 12'h301, 8'h00, 8'h00, 8'h00, 3'b100));
        vecs.push_back(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
        vecs[0].rst_before = 1'b1;
        vecs[3].rst_before = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            apply(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset lands in the cycle the read response is due.
        do_reset();
        apply(mk(3'b001, 3'b000, 12'h051, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b001), "t4.read");
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(3'b010, 3'b010, 12'h000, 12'h3FF, 12'h000, 8'h00, 8'h77, 8'h00, 3'b000));
        @(negedge clk);
        check("t4.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("t4.mem_read",   32'(mem_read),       32'd0);
        check("t4.mem_write",  32'(mem_write),      32'd0);
        check("t4.ready",      32'(bus.req_ready),  32'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000));
        @(negedge clk);
        check("t4.resp_after", 32'(bus.resp_valid), 32'd0);
        check("t4.mem_kept",   32'(mem[12'h3FF]),   32'(pat(12'h3FF)));
        apply(mk(3'b011, 3'b000, 12'h052, 12'h053, 12'h000, 8'h00, 8'h00, 8'h00, 3'b001), "t4.ptr0");
        apply(mk(3'b010, 3'b000, 12'h052, 12'h053, 12'h000, 8'h00, 8'h00, 8'h00, 3'b010), "t4.next");
        apply(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000), "t4.drain");

`ifdef MEM_ARB_LOCK_EN
        // Locked 16-byte loader burst holds off a waiting CPU.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            v = mk((n == 0) ? 3'b100 : 3'b101, 3'b100, 12'h050, 12'h000, 12'(n),
                   8'h00, 8'h00, 8'(8'h80 + n), 3'b100);
            v.lock = (n < 15) ? 3'b100 : 3'b000;
            apply(v, $sformatf("t5.burst%0d", n));
        end
        apply(mk(3'b001, 3'b000, 12'h050, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b001), "t5.cpu");
        apply(mk(3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000), "t5.drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
